// File: rtl/scroll_text_buffer.sv
// Message store for the 8-digit 7-seg scanner: appends 6-bit character codes and presents an
// 8-character window that is held static, stepped, or auto-scrolled around a trailing blank gap.
module scroll_text_buffer #(
    parameter int MSG_DEPTH  = 16,
    parameter int SCROLL_DIV = 50000000,
    parameter int GAP        = 2,
    parameter int LEN_W      = $clog2(MSG_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [5:0]       wr_char,
    input  logic             scroll_en,
    input  logic             step,
    output logic [5:0]       x7_out,
    output logic [5:0]       x6_out,
    output logic [5:0]       x5_out,
    output logic [5:0]       x4_out,
    output logic [5:0]       x3_out,
    output logic [5:0]       x2_out,
    output logic [5:0]       x1_out,
    output logic [5:0]       x0_out,
    output logic [LEN_W-1:0] len,
    output logic             full,
    output logic             ovf
);
    localparam int PW = $clog2(MSG_DEPTH + GAP + 1);
    localparam int DW = $clog2(SCROLL_DIV);
    localparam logic [5:0] BLANK = 6'd63;

    logic [5:0]       msg_q [MSG_DEPTH];
    logic [5:0]       msg_d [MSG_DEPTH];
    logic [LEN_W-1:0] len_q, len_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [DW-1:0]    div_q, div_d;
    logic             ovf_q, ovf_d;

    logic [PW-1:0]    stream_len;
    logic             tick, advance;
    logic [PW-1:0]    idx;
    logic [5:0]       win [8];

    always_comb begin
        msg_d      = msg_q;
        len_d      = len_q;
        pos_d      = pos_q;
        div_d      = div_q;
        ovf_d      = 1'b0;
        full       = (len_q == LEN_W'(MSG_DEPTH));
        stream_len = PW'(len_q) + PW'(GAP);
        tick       = scroll_en && (len_q != '0) && (div_q == DW'(SCROLL_DIV - 1));
        advance    = (len_q != '0) && (tick || (!scroll_en && step));
        if (clr) begin
            len_d = '0;
            pos_d = '0;
            div_d = '0;
        end else begin
            if (scroll_en && (len_q != '0))
                div_d = tick ? '0 : DW'(div_q + 1'b1);
            else
                div_d = '0;
            // Wrap uses the pre-write stream length even if a write lands this edge.
            if (advance)
                pos_d = (PW'(pos_q + 1'b1) == stream_len) ? '0 : PW'(pos_q + 1'b1);
            if (wr_en) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    for (int j = 0; j < MSG_DEPTH; j++)
                        if (LEN_W'(j) == len_q)
                            msg_d[j] = (wr_char > 6'd35) ? BLANK : wr_char;
                    len_d = LEN_W'(len_q + 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < MSG_DEPTH; j++) msg_q[j] <= BLANK;
            len_q <= '0;
            pos_q <= '0;
            div_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            msg_q <= msg_d;
            len_q <= len_d;
            pos_q <= pos_d;
            div_q <= div_d;
            ovf_q <= ovf_d;
        end
    end

    // Walk the virtual stream from pos, wrapping at L; entries past len read as blank.
    always_comb begin
        idx = pos_q;
        for (int i = 0; i < 8; i++) begin
            win[i] = BLANK;
            for (int j = 0; j < MSG_DEPTH; j++)
                if ((PW'(j) == idx) && (idx < PW'(len_q)))
                    win[i] = msg_q[j];
            idx = (PW'(idx + 1'b1) == stream_len) ? '0 : PW'(idx + 1'b1);
        end
    end

    assign x7_out = win[0];
    assign x6_out = win[1];
    assign x5_out = win[2];
    assign x4_out = win[3];
    assign x3_out = win[4];
    assign x2_out = win[5];
    assign x1_out = win[6];
    assign x0_out = win[7];
    assign len    = len_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_scroll_text_buffer.sv
// Directed bench for scroll_text_buffer with SCROLL_DIV=4, GAP=2, MSG_DEPTH=16.
module tb_scroll_text_buffer;
    logic       clk = 1'b0;
    logic       rst, clr, wr_en, scroll_en, step;
    logic [5:0] wr_char;
    logic [5:0] x7, x6, x5, x4, x3, x2, x1, x0;
    logic [4:0] len;
    logic       full, ovf;
    int         n_vec = 0;
    int         n_err = 0;

    localparam int B = 63;

    scroll_text_buffer #(.MSG_DEPTH(16), .SCROLL_DIV(4), .GAP(2)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_char(wr_char),
        .scroll_en(scroll_en), .step(step),
        .x7_out(x7), .x6_out(x6), .x5_out(x5), .x4_out(x4),
        .x3_out(x3), .x2_out(x2), .x1_out(x1), .x0_out(x0),
        .len(len), .full(full), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] w8(input int a, b, c, d, e, f, g, h);
        return {6'(a), 6'(b), 6'(c), 6'(d), 6'(e), 6'(f), 6'(g), 6'(h)};
    endfunction

    task automatic expect_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [47:0] exp);
        expect_eq(tag, {x7, x6, x5, x4, x3, x2, x1, x0}, exp);
    endtask

    task automatic wr(input int c);
        wr_en = 1'b1; wr_char = 6'(c);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_char = '0; scroll_en = 1'b0; step = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_win("reset_win", w8(B, B, B, B, B, B, B, B));
        expect_eq("reset_len", 48'(len), 48'd0);
        expect_eq("reset_full", 48'(full), 48'd0);
        expect_eq("reset_ovf", 48'(ovf), 48'd0);

        // L=5 stream 1,2,3,_,_ wraps inside the 8-wide window
        wr(1); wr(2); wr(3);
        expect_eq("len3", 48'(len), 48'd3);
        chk_win("static_pos0", w8(1, 2, 3, B, B, 1, 2, 3));

        scroll_en = 1'b1;
        repeat (4) @(negedge clk);
        chk_win("scroll_pos1", w8(2, 3, B, B, 1, 2, 3, B));
        repeat (4) @(negedge clk);
        chk_win("scroll_pos2", w8(3, B, B, 1, 2, 3, B, B));
        repeat (4) @(negedge clk);
        chk_win("scroll_pos3", w8(B, B, 1, 2, 3, B, B, 1));
        repeat (4) @(negedge clk);
        chk_win("scroll_pos4", w8(B, 1, 2, 3, B, B, 1, 2));
        repeat (4) @(negedge clk);
        chk_win("scroll_wrap0", w8(1, 2, 3, B, B, 1, 2, 3));

        scroll_en = 1'b0;
        repeat (3) pulse_step();
        chk_win("step3_pos3", w8(B, B, 1, 2, 3, B, B, 1));
        repeat (6) @(negedge clk);
        chk_win("static_hold", w8(B, B, 1, 2, 3, B, B, 1));

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        expect_eq("clr_len", 48'(len), 48'd0);
        chk_win("clr_win", w8(B, B, B, B, B, B, B, B));

        for (int i = 0; i < 16; i++) wr(i);
        expect_eq("len16", 48'(len), 48'd16);
        expect_eq("full16", 48'(full), 48'd1);
        expect_eq("ovf_pre", 48'(ovf), 48'd0);
        wr(20);
        expect_eq("ovf_set", 48'(ovf), 48'd1);
        expect_eq("ovf_len", 48'(len), 48'd16);
        @(negedge clk);
        expect_eq("ovf_clear", 48'(ovf), 48'd0);
        chk_win("full_win", w8(0, 1, 2, 3, 4, 5, 6, 7));
        repeat (8) pulse_step();
        chk_win("full_tail", w8(8, 9, 10, 11, 12, 13, 14, 15));

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        pulse_step();
        wr(40); wr(5);
        // A stray step on the empty buffer would leave pos=1 and shift this window
        chk_win("empty_step_code40", w8(B, 5, B, B, B, 5, B, B));

        scroll_en = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b1; wr_en = 1'b1; wr_char = 6'd7;
        @(negedge clk);
        clr = 1'b0; wr_en = 1'b0;
        expect_eq("clr_wins_len", 48'(len), 48'd0);
        chk_win("clr_wins_win", w8(B, B, B, B, B, B, B, B));

        scroll_en = 1'b0;
        wr(1); wr(2); wr(3);
        scroll_en = 1'b1;
        repeat (6) @(negedge clk);
        chk_win("pre_rst_pos1", w8(2, 3, B, B, 1, 2, 3, B));
        #2 rst = 1'b1;
        #1;
        expect_eq("rst_len", 48'(len), 48'd0);
        chk_win("rst_win", w8(B, B, B, B, B, B, B, B));
        @(negedge clk);
        rst = 1'b0;
        scroll_en = 1'b0;
        @(negedge clk);
        expect_eq("rst_full", 48'(full), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
